// File: rtl/branch_predictor_table_if.sv
// Predictor bus: resolution update from the ECR file, flush, issue-stage
// lookup and the table's status/prediction outputs.
interface branch_predictor_table_if;
    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic        actual_taken;
    } bp_update_t;

    bp_update_t  bp_update;
    logic        flush_req;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        ready;
    logic [31:0] upd_count;
    logic [31:0] drop_count;

    modport master (
        output bp_update, flush_req, lookup_pc,
        input  pred_taken, ready, upd_count, drop_count
    );

    modport slave (
        input  bp_update, flush_req, lookup_pc,
        output pred_taken, ready, upd_count, drop_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of 2-bit saturating direction counters indexed by pc[IDX_W+1:2].
// After reset or flush the table is swept to INIT_CTR one entry per cycle;
// predictions are valid (ready=1) only once the sweep has finished.
module branch_predictor_table #(
    parameter int         NUM_ENTRIES = 64,
    parameter logic [1:0] INIT_CTR    = 2'b01
) (
    input logic                     clk,
    input logic                     rst_n,
    branch_predictor_table_if.slave bp
);
    localparam int               IDX_W    = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [31:0]      upd_count_q, upd_count_d;
    logic [31:0]      drop_count_q, drop_count_d;
    logic [1:0]       ctr_q [NUM_ENTRIES];
    logic [1:0]       ctr_d [NUM_ENTRIES];

    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [1:0]       upd_val;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    // Word-aligned PC index; upper PC bits are dropped so distant branches alias.
    assign upd_idx    = IDX_W'(bp.bp_update.pc >> 2);
    assign lookup_idx = IDX_W'(bp.lookup_pc >> 2);
    assign upd_val    = sat_ctr(ctr_q[upd_idx], bp.bp_update.actual_taken);

    // Next state: INIT sweep writes, RUN updates, drop/update counting, flush restart.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        upd_count_d  = upd_count_q;
        drop_count_d = drop_count_q;
        ctr_d        = ctr_q;
        case (state_q)
            ST_INIT: begin
                ctr_d[init_ptr_q] = INIT_CTR;
                init_ptr_d        = init_ptr_q + IDX_W'(1);
                if (bp.bp_update.en) begin
                    drop_count_d = drop_count_q + 32'd1;
                end
                if (init_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bp.bp_update.en) begin
                    ctr_d[upd_idx] = upd_val;
                    upd_count_d    = upd_count_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        // A flush still lets this cycle's RUN update land; only the sweep restarts.
        if (bp.flush_req) begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
        end
    end

    // Control registers, cleared asynchronously so reset aborts activity at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            upd_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            upd_count_q  <= upd_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Counter storage is unreset; the INIT sweep gives it defined contents.
    always_ff @(posedge clk) begin
        ctr_q <= ctr_d;
    end

    // Prediction with same-cycle bypass of an update hitting the looked-up entry.
    always_comb begin
        bp.pred_taken = 1'b0;
        if (state_q == ST_RUN) begin
            if (bp.bp_update.en && (upd_idx == lookup_idx)) begin
                bp.pred_taken = upd_val[1];
            end else begin
                bp.pred_taken = ctr_q[lookup_idx][1];
            end
        end
    end

    assign bp.ready      = (state_q == ST_RUN);
    assign bp.upd_count  = upd_count_q;
    assign bp.drop_count = drop_count_q;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table: a stimulus process drives one
// transaction per cycle and queues the reference model's expected outputs; a
// monitor on the falling edge pops and compares them.
module tb_branch_predictor_table;
    localparam int         N    = 64;
    localparam logic [1:0] INIT = 2'b01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_table_if bus ();

    branch_predictor_table #(
        .NUM_ENTRIES(N),
        .INIT_CTR   (INIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bus.slave)
    );

    typedef struct packed {
        logic        ready;
        logic        pred;
        logic [31:0] upd;
        logic [31:0] drop;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model: table contents, sweep progress and counters.
    int          tbl[N];
    bit          running;
    int          remaining;
    logic [31:0] m_upd;
    logic [31:0] m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int next_ctr(input int c, input bit taken);
        if (taken) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic reset_model();
        running   = 1'b0;
        remaining = N;
        m_upd     = '0;
        m_drop    = '0;
    endtask

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input bit en, input logic [31:0] pc, input bit taken,
                         input bit flush, input logic [31:0] lpc);
        exp_t e;
        int   ui, li, nv;
        bus.bp_update.en           = en;
        bus.bp_update.pc           = pc;
        bus.bp_update.actual_taken = taken;
        bus.flush_req              = flush;
        bus.lookup_pc              = lpc;
        ui = idx_of(pc);
        li = idx_of(lpc);
        nv = next_ctr(tbl[ui], taken);
        e.ready = running;
        if (!running)             e.pred = 1'b0;
        else if (en && ui == li)  e.pred = (nv >= 2);
        else                      e.pred = (tbl[li] >= 2);
        e.upd  = m_upd;
        e.drop = m_drop;
        sb.push_back(e);
        @(posedge clk);
        if (en && running) begin
            tbl[ui] = nv;
            m_upd   = m_upd + 32'd1;
        end else if (en) begin
            m_drop = m_drop + 32'd1;
        end
        if (flush) begin
            running   = 1'b0;
            remaining = N;
        end else if (!running) begin
            remaining--;
            if (remaining == 0) begin
                running = 1'b1;
                foreach (tbl[i]) tbl[i] = int'(INIT);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, $urandom(), 1'($urandom_range(0, 1)), 1'b0, $urandom());
        end
    endtask

    task automatic finish_sweep();
        for (int k = 0; k < 2 * N && !running; k++) idle(1);
    endtask

    task automatic scan_table();
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'(i * 4) | 32'h1230_0000);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_pred"},  32'(bus.pred_taken), 32'd0);
        chk({tag, "_upd"},   bus.upd_count, 32'd0);
        chk({tag, "_drop"},  bus.drop_count, 32'd0);
    endtask

    // Monitor: compare one queued expectation per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ready",      32'(bus.ready), 32'(e.ready));
            chk("pred_taken", 32'(bus.pred_taken), 32'(e.pred));
            chk("upd_count",  bus.upd_count, e.upd);
            chk("drop_count", bus.drop_count, e.drop);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bp_update = '0;
        bus.flush_req = 1'b0;
        bus.lookup_pc = 32'h100;
        foreach (tbl[i]) tbl[i] = 0;
        reset_model();

        // Held in reset with an active update request.
        bus.bp_update.en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        bus.bp_update.en = 1'b0;
        rst_n = 1'b1;

        // Sweep after release, then every entry reads weakly not-taken.
        idle(N);
        idle(1);
        scan_table();

        // Taken x3 on 0x100 with lookup on the same PC, then alias 0x200.
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h100);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h200);

        // Not-taken x5 via the aliasing PC drives the shared counter to 00 and holds.
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'h200, 1'b0, 1'b0, 32'h100);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FD00);

        // Same-cycle bypass on a fresh 01 entry.
        cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h40);

        // Randomized traffic with aliasing, bypass hits and occasional flushes.
        for (int k = 0; k < 500; k++) begin
            logic [31:0] pc, lpc;
            int          r;
            pc  = $urandom() & 32'hFFFF_F03C;
            r   = $urandom_range(0, 3);
            lpc = (r == 0) ? pc : (r == 1) ? (pc ^ 32'h0004_0000) : ($urandom() & 32'h0000_00FC);
            cycle(1'($urandom_range(0, 2) != 0), pc, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 79) == 0), lpc);
        end

        // Flush in RUN with a simultaneous update, then two drops during INIT.
        finish_sweep();
        cycle(1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
        cycle(1'b1, 32'h104, 1'b1, 1'b0, 32'h104);
        idle(5);
        cycle(1'b1, 32'h108, 1'b0, 1'b0, 32'h108);
        finish_sweep();
        scan_table();

        // Flush in INIT restarts the sweep.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        idle(20);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        finish_sweep();
        idle(2);

        // Asynchronous reset at init_ptr=30 of a flush sweep.
        cycle(1'b1, 32'h100, 1'b1, 1'b1, 32'h100);
        idle(30);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        rst_n = 1'b1;
        reset_model();
        idle(N);
        scan_table();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] pc;
            pc = $urandom() & 32'h0000_003C;
            cycle(1'b1, pc, 1'($urandom_range(0, 1)), 1'b0, pc);
        end

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
